mem_stage: RTL and testbench

- Pipeline MEM stage of the 8-bit RISC core; consumes the EX/MEM register outputs and produces the MEM/WB register.
- Drives a request/acknowledge data-memory port with variable latency. Address comes from the ALU result; store data comes from the forwarded write data.
- Stalls the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) while an access is outstanding.
- Bounds each access with a timeout and keeps a sticky error flag.

---
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the 8-bit RISC core: drives a req/ack data-memory port, stalls upstream
// while an access is outstanding, bounds each access with a timeout and builds MEM/WB.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       regwrite_in,
  input  logic       memread_in,
  input  logic       memwrite_in,
  input  logic       mem_to_reg_in,
  input  logic [7:0] alu_result_in,
  input  logic [7:0] write_data_in,
  input  logic [2:0] rd_in,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic [7:0] dmem_addr,
  output logic [7:0] dmem_wdata,
  input  logic [7:0] dmem_rdata,
  input  logic       dmem_ack,
  output logic       stall,
  output logic       mem_err,
  output logic       regwrite_memwb,
  output logic       mem_to_reg_memwb,
  output logic [7:0] read_data_memwb,
  output logic [7:0] alu_result_memwb,
  output logic [2:0] rd_memwb
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       req_q, req_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       err_q, err_d;
  logic       regwrite_q, regwrite_d;
  logic       m2r_q, m2r_d;
  logic [7:0] rdata_q, rdata_d;
  logic [7:0] alu_q, alu_d;
  logic [2:0] rd_q, rd_d;
  logic       stall_raw;
  logic       memop;
  logic       timeout;

  assign memop   = memread_in | memwrite_in;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    // MEM/WB defaults to a bubble; completing paths overwrite it.
    regwrite_d = 1'b0;
    m2r_d      = 1'b0;
    rdata_d    = 8'h00;
    alu_d      = 8'h00;
    rd_d       = 3'd0;
    stall_raw  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall_raw = 1'b1;
          req_d     = 1'b1;
          we_d      = memwrite_in & ~memread_in;
          addr_d    = alu_result_in;
          wdata_d   = write_data_in;
          cnt_d     = '0;
          state_d   = ACCESS;
          if (memread_in && memwrite_in) err_d = 1'b1;
        end else begin
          regwrite_d = regwrite_in;
          m2r_d      = mem_to_reg_in;
          alu_d      = alu_result_in;
          rd_d       = rd_in;
        end
      end
      ACCESS: begin
        if (dmem_ack || timeout) begin
          regwrite_d = regwrite_in;
          m2r_d      = mem_to_reg_in;
          alu_d      = alu_result_in;
          rd_d       = rd_in;
          req_d      = 1'b0;
          state_d    = IDLE;
          if (dmem_ack) begin
            rdata_d = we_q ? 8'h00 : dmem_rdata;
          end else begin
            rdata_d = 8'hFF;
            err_d   = 1'b1;
          end
        end else begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      err_q      <= 1'b0;
      regwrite_q <= 1'b0;
      m2r_q      <= 1'b0;
      rdata_q    <= 8'h00;
      alu_q      <= 8'h00;
      rd_q       <= 3'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      regwrite_q <= regwrite_d;
      m2r_q      <= m2r_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
    end
  end

  // Stall is forced low while reset is held so upstream is released immediately.
  assign stall            = rst & stall_raw;
  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign mem_err          = err_q;
  assign regwrite_memwb   = regwrite_q;
  assign mem_to_reg_memwb = m2r_q;
  assign read_data_memwb  = rdata_q;
  assign alu_result_memwb = alu_q;
  assign rd_memwb         = rd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios then random ops, checked against a
// transaction-level model of latency, stall, MEM/WB contents and the sticky error.
module tb_mem_stage;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       regwrite_in = 0, memread_in = 0, memwrite_in = 0, mem_to_reg_in = 0;
  logic [7:0] alu_result_in = 0, write_data_in = 0, dmem_rdata = 0;
  logic [2:0] rd_in = 0;
  logic       dmem_ack = 0;
  logic       dmem_req, dmem_we, stall, mem_err;
  logic [7:0] dmem_addr, dmem_wdata;
  logic       regwrite_memwb, mem_to_reg_memwb;
  logic [7:0] read_data_memwb, alu_result_memwb;
  logic [2:0] rd_memwb;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic err_m   = 1'b0;

  mem_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .regwrite_in(regwrite_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
    .mem_to_reg_in(mem_to_reg_in), .alu_result_in(alu_result_in),
    .write_data_in(write_data_in), .rd_in(rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .mem_err(mem_err),
    .regwrite_memwb(regwrite_memwb), .mem_to_reg_memwb(mem_to_reg_memwb),
    .read_data_memwb(read_data_memwb), .alu_result_memwb(alu_result_memwb),
    .rd_memwb(rd_memwb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_memwb(input logic rw, input logic m2r, input logic [7:0] a,
                             input logic [2:0] r, input logic [7:0] rdat);
    check("regwrite_memwb", {7'd0, regwrite_memwb}, {7'd0, rw});
    check("mem_to_reg_memwb", {7'd0, mem_to_reg_memwb}, {7'd0, m2r});
    check("alu_result_memwb", alu_result_memwb, a);
    check("rd_memwb", {5'd0, rd_memwb}, {5'd0, r});
    check("read_data_memwb", read_data_memwb, rdat);
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 load+store; d = ACCESS cycle carrying the ack (d > T: never)
  task automatic run_op(input int kind, input logic rw, input logic m2r, input logic [7:0] a,
                        input logic [7:0] wd, input logic [2:0] r, input int d,
                        input logic [7:0] rdv);
    logic is_rd, is_wr, memop, timed_out;
    int   n;
    is_rd = (kind == 1) || (kind == 3);
    is_wr = (kind == 2) || (kind == 3);
    memop = is_rd | is_wr;
    regwrite_in = rw; mem_to_reg_in = m2r; memread_in = is_rd; memwrite_in = is_wr;
    alu_result_in = a; write_data_in = wd; rd_in = r; dmem_ack = 1'b0;
    #1;
    check("stall_idle", {7'd0, stall}, {7'd0, memop});
    tick();
    if (!memop) begin
      check_memwb(rw, m2r, a, r, 8'h00);
      check("req_alu", {7'd0, dmem_req}, 8'h00);
      check("mem_err", {7'd0, mem_err}, {7'd0, err_m});
    end else begin
      if (is_rd && is_wr) err_m = 1'b1;
      timed_out = (d > T);
      n = timed_out ? T : d;
      check("regwrite_bubble", {7'd0, regwrite_memwb}, 8'h00);
      check("m2r_bubble", {7'd0, mem_to_reg_memwb}, 8'h00);
      check("mem_err_issue", {7'd0, mem_err}, {7'd0, err_m});
      for (int k = 1; k <= n; k++) begin
        dmem_ack   = (k == d);
        dmem_rdata = (k == d) ? rdv : 8'($urandom);
        #1;
        check("stall_access", {7'd0, stall}, {7'd0, (k < n)});
        check("req_held", {7'd0, dmem_req}, 8'h01);
        check("we", {7'd0, dmem_we}, {7'd0, is_wr & ~is_rd});
        check("addr", dmem_addr, a);
        check("wdata", dmem_wdata, wd);
        tick();
        if (k < n) check("regwrite_bubble_acc", {7'd0, regwrite_memwb}, 8'h00);
      end
      dmem_ack = 1'b0;
      if (timed_out) err_m = 1'b1;
      check("req_done", {7'd0, dmem_req}, 8'h00);
      check_memwb(rw, m2r, a, r,
                  timed_out ? 8'hFF : ((is_wr && !is_rd) ? 8'h00 : rdv));
      check("mem_err_done", {7'd0, mem_err}, {7'd0, err_m});
    end
  endtask

  initial begin
    #3 rst = 1'b0;
    #1;
    check("rst_req", {7'd0, dmem_req}, 8'h00);
    check("rst_err", {7'd0, mem_err}, 8'h00);
    check_memwb(1'b0, 1'b0, 8'h00, 3'd0, 8'h00);
    tick();
    tick();
    rst = 1'b1;

    run_op(0, 1'b1, 1'b0, 8'h3C, 8'h00, 3'd5, 1, 8'h00);      // ALU op
    run_op(1, 1'b1, 1'b1, 8'h12, 8'h00, 3'd2, 1, 8'hA5);      // load, ack immediately
    run_op(2, 1'b0, 1'b0, 8'h40, 8'h7E, 3'd1, 3, 8'h00);      // store, ack after 3
    run_op(1, 1'b1, 1'b1, 8'h55, 8'h00, 3'd3, T + 5, 8'h00);  // load timeout
    run_op(0, 1'b1, 1'b0, 8'h01, 8'h00, 3'd4, 1, 8'h00);      // error stays sticky
    run_op(3, 1'b1, 1'b1, 8'h66, 8'h99, 3'd6, 2, 8'h5A);      // read+write conflict

    // Reset in the middle of an access
    regwrite_in = 1; mem_to_reg_in = 1; memread_in = 1; memwrite_in = 0;
    alu_result_in = 8'h77; rd_in = 3'd7;
    tick(); tick(); tick();
    #2 rst = 1'b0;
    #1;
    err_m = 1'b0;
    check("rst_mid_req", {7'd0, dmem_req}, 8'h00);
    check("rst_mid_stall", {7'd0, stall}, 8'h00);
    check("rst_mid_err", {7'd0, mem_err}, 8'h00);
    check("rst_mid_addr", dmem_addr, 8'h00);
    check_memwb(1'b0, 1'b0, 8'h00, 3'd0, 8'h00);
    memread_in = 0; regwrite_in = 0; mem_to_reg_in = 0;
    tick(); tick();
    rst = 1'b1;

    // Stray ack in IDLE with an ALU op
    regwrite_in = 1; mem_to_reg_in = 0; memread_in = 0; memwrite_in = 0;
    alu_result_in = 8'hC3; rd_in = 3'd2; dmem_ack = 1; dmem_rdata = 8'hEE;
    #1;
    check("stray_stall", {7'd0, stall}, 8'h00);
    tick();
    dmem_ack = 0;
    check("stray_req", {7'd0, dmem_req}, 8'h00);
    check_memwb(1'b1, 1'b0, 8'hC3, 3'd2, 8'h00);
    run_op(1, 1'b1, 1'b1, 8'h21, 8'h00, 3'd1, 2, 8'h3E);

    for (int i = 0; i < 60; i++) begin
      run_op(int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom),
             8'($urandom), 3'($urandom), int'($urandom_range(1, T + 2)), 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
